// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised 2-read / 2-write register file with optional
// write-through bypass, synchronous clear and a per-register busy scoreboard
// tracking in-flight loads. Register 0 is hard-wired to zero and never busy.
module reg_file_sb #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned OUT_IDX = 2**ADDR_W - 1,
    parameter bit          BYPASS  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] RA1,
    input  logic [ADDR_W-1:0] RA2,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] WA,
    input  logic [DATA_W-1:0] WD,
    input  logic              write_enable2,
    input  logic [ADDR_W-1:0] WA2,
    input  logic [DATA_W-1:0] WD2,
    input  logic              reserve_en,
    input  logic [ADDR_W-1:0] reserve_addr,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic              busy1,
    output logic              busy2,
    output logic [DATA_W-1:0] cpu_out,
    output logic              reserve_err
);

    localparam int unsigned DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] rf [DEPTH];
    logic [DEPTH-1:0]  busy;

    // Effective (non-zero address) write / reserve qualifiers
    logic wr_a;
    logic wr_b;
    logic rsv;

    // Qualify enables with the register-0 exclusion
    always_comb begin
        wr_a = write_enable  && (WA != '0);
        wr_b = write_enable2 && (WA2 != '0);
        rsv  = reserve_en    && (reserve_addr != '0);
    end

    // Register storage: port A overrides port B on an address collision
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                rf[i] <= '0;
            end
        end else begin
            for (int i = 1; i < int'(DEPTH); i++) begin
                if (wr_a && (WA == ADDR_W'(i))) begin
                    rf[i] <= WD;
                end else if (wr_b && (WA2 == ADDR_W'(i))) begin
                    rf[i] <= WD2;
                end
            end
        end
    end

    // Scoreboard: a new reservation beats a same-cycle load retirement
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy[0] <= 1'b0;
            for (int i = 1; i < int'(DEPTH); i++) begin
                if (rsv && (reserve_addr == ADDR_W'(i))) begin
                    busy[i] <= 1'b1;
                end else if (wr_b && (WA2 == ADDR_W'(i))) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    // Sticky error: reserving a register whose load has not yet retired
    always_ff @(posedge clk) begin
        if (reset) begin
            reserve_err <= 1'b0;
        end else if (rsv && busy[reserve_addr] && !(wr_b && (WA2 == reserve_addr))) begin
            reserve_err <= 1'b1;
        end
    end

    // Read port 1 with optional same-cycle forwarding
    always_comb begin
        RD1   = rf[RA1];
        busy1 = busy[RA1];
        if (RA1 == '0) begin
            RD1   = '0;
            busy1 = 1'b0;
        end else if (BYPASS) begin
            if (wr_a && (WA == RA1)) begin
                RD1 = WD;
            end else if (wr_b && (WA2 == RA1)) begin
                RD1 = WD2;
            end
            if (wr_b && (WA2 == RA1) && !(rsv && (reserve_addr == RA1))) begin
                busy1 = 1'b0;
            end
        end
    end

    // Read port 2 with optional same-cycle forwarding
    always_comb begin
        RD2   = rf[RA2];
        busy2 = busy[RA2];
        if (RA2 == '0) begin
            RD2   = '0;
            busy2 = 1'b0;
        end else if (BYPASS) begin
            if (wr_a && (WA == RA2)) begin
                RD2 = WD;
            end else if (wr_b && (WA2 == RA2)) begin
                RD2 = WD2;
            end
            if (wr_b && (WA2 == RA2) && !(rsv && (reserve_addr == RA2))) begin
                busy2 = 1'b0;
            end
        end
    end

    // Architectural output register, never bypassed
    generate
        if (OUT_IDX == 0) begin : g_out_zero
            always_comb cpu_out = '0;
        end else begin : g_out_reg
            always_comb cpu_out = rf[ADDR_W'(OUT_IDX)];
        end
    endgenerate

endmodule
